// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle between decode and the register scoreboard.
//
// Handshake: an issue transfers on a rising edge when iss_valid=1 and
// stall=0 (stall is the inverse of ready and is combinational), with flush=0
// and the scoreboard out of reset. Writebacks (wb_valid/wb_rd) are never
// back-pressured; they complete in the cycle they are presented.
interface reg_scoreboard_if;
  logic        iss_valid;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_use_rs1;
  logic        iss_use_rs2;
  logic        iss_wr;
  logic [4:0]  iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic [31:0] pend;
  logic [5:0]  busy_cnt;
  logic        wb_err;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
    output iss_wr, iss_rd, wb_valid, wb_rd, flush,
    input  stall, pend, busy_cnt, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
    input  iss_wr, iss_rd, wb_valid, wb_rd, flush,
    output stall, pend, busy_cnt, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register.
// Blocks issue on RAW and WAW hazards, tracks a pending count and flags
// writebacks to registers that had no write outstanding.
// Optional macro SB_WB_BYPASS_EN: a hazard on the register being written back
// in the same cycle is ignored (writeback bypass). Without it that hazard
// stalls for the cycle and releases on the next.
module reg_scoreboard (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);

  logic [31:0] pend_q;
  logic [31:0] pend_n;
  logic [5:0]  busy_q;
  logic [5:0]  busy_n;
  logic        wb_err_q;
  logic        wb_err_n;
  logic        byp_en;
  logic        haz_rs1;
  logic        haz_rs2;
  logic        haz_rd;
  logic        stall_c;
  logic        accept;

`ifdef SB_WB_BYPASS_EN
  assign byp_en = sb.wb_valid & ~sb.flush;
`else
  assign byp_en = 1'b0;
`endif

  // Hazard detection and issue acceptance; pend_q[0] is never set so x0
  // cannot raise a hazard.
  always_comb begin
    haz_rs1 = sb.iss_use_rs1 & pend_q[sb.iss_rs1] & ~(byp_en & (sb.wb_rd == sb.iss_rs1));
    haz_rs2 = sb.iss_use_rs2 & pend_q[sb.iss_rs2] & ~(byp_en & (sb.wb_rd == sb.iss_rs2));
    haz_rd  = sb.iss_wr      & pend_q[sb.iss_rd]  & ~(byp_en & (sb.wb_rd == sb.iss_rd));
    stall_c = sb.iss_valid & ~sb.flush & ~reset & (haz_rs1 | haz_rs2 | haz_rd);
    accept  = sb.iss_valid & ~stall_c & ~sb.flush & ~reset;
  end

  // Next pending vector: clear on writeback, then set on issue so a set wins
  // over a clear of the same register; flush discards everything.
  always_comb begin
    pend_n = pend_q;
    if (sb.wb_valid) begin
      pend_n[sb.wb_rd] = 1'b0;
    end
    if (accept & sb.iss_wr) begin
      pend_n[sb.iss_rd] = 1'b1;
    end
    pend_n[0] = 1'b0;
    if (sb.flush) begin
      pend_n = '0;
    end
    wb_err_n = sb.wb_valid & ~sb.flush & (sb.wb_rd != 5'd0) & ~pend_q[sb.wb_rd];
  end

  // Population count of the next pending vector, registered with it.
  always_comb begin
    busy_n = '0;
    for (int i = 1; i < 32; i++) begin
      busy_n = busy_n + {5'd0, pend_n[i]};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_n;
      busy_q   <= busy_n;
      wb_err_q <= wb_err_n;
    end
  end

  assign sb.stall    = stall_c;
  assign sb.pend     = pend_q;
  assign sb.busy_cnt = busy_q;
  assign sb.wb_err   = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a random
// run compared against a register-array reference model.
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_scoreboard_if sb ();

  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  // Reference model: which registers have a write outstanding.
  bit m_pend[32];
  bit m_err;

  function automatic bit hazard_on(logic [4:0] r, logic used);
    if (!used || r == 5'd0 || !m_pend[r]) return 1'b0;
    if (BYP && sb.wb_valid && !sb.flush && r == sb.wb_rd) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    if (!sb.iss_valid || sb.flush || reset) return 1'b0;
    return hazard_on(sb.iss_rs1, sb.iss_use_rs1) ||
           hazard_on(sb.iss_rs2, sb.iss_use_rs2) ||
           hazard_on(sb.iss_rd,  sb.iss_wr);
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [5:0] exp_busy();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return 6'(n);
  endfunction

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic tick();
    bit nxt[32];
    bit acc;
    bit err;
    acc = sb.iss_valid && !exp_stall() && !sb.flush && !reset;
    err = !reset && !sb.flush && sb.wb_valid && sb.wb_rd != 5'd0 && !m_pend[sb.wb_rd];
    nxt = m_pend;
    if (reset || sb.flush) begin
      for (int i = 0; i < 32; i++) nxt[i] = 1'b0;
    end else begin
      if (sb.wb_valid && sb.wb_rd != 5'd0) nxt[sb.wb_rd] = 1'b0;
      if (acc && sb.iss_wr && sb.iss_rd != 5'd0) nxt[sb.iss_rd] = 1'b1;
    end
    @(posedge clk);
    m_pend = nxt;
    m_err  = err;
    #1;
  endtask

  task automatic drive_iss(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic wr, input logic [4:0] rd);
    sb.iss_valid   = v;
    sb.iss_rs1     = rs1;
    sb.iss_use_rs1 = u1;
    sb.iss_rs2     = rs2;
    sb.iss_use_rs2 = u2;
    sb.iss_wr      = wr;
    sb.iss_rd      = rd;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] rd);
    sb.wb_valid = v;
    sb.wb_rd    = rd;
  endtask

  task automatic idle();
    drive_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    drive_wb(1'b0, 5'd0);
    sb.flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_iss(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 5'd8);
    drive_wb(1'b1, 5'd9);
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", sb.stall); end
    tick();
    tick();
    checks++;
    if (sb.pend !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h want 0", sb.pend); end
    checks++;
    if (sb.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy: got %0d want 0", sb.busy_cnt); end
    checks++;
    if (sb.wb_err !== 1'b0) begin errors++; $display("FAIL reset_wberr: got %b want 0", sb.wb_err); end
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_raw();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall: got %b want 0", sb.stall); end
    tick();
    checks++;
    if (sb.pend !== 32'h20) begin errors++; $display("FAIL raw_pend: got %h want 00000020", sb.pend); end
    checks++;
    if (sb.busy_cnt !== 6'd1) begin errors++; $display("FAIL raw_busy: got %0d want 1", sb.busy_cnt); end
    drive_iss(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (sb.stall !== 1'b1) begin errors++; $display("FAIL raw_stall: cycle %0d got %b want 1", i, sb.stall); end
      tick();
    end
    drive_wb(1'b1, 5'd5);
    #1;
    checks++;
    if (sb.stall !== !BYP) begin errors++; $display("FAIL raw_wb_stall: got %b want %b", sb.stall, !BYP); end
    tick();
    drive_wb(1'b0, 5'd0);
    checks++;
    if (sb.pend[5] !== 1'b0) begin errors++; $display("FAIL raw_clear: got %b want 0", sb.pend[5]); end
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", sb.stall); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_bypass();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
    tick();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0);
    drive_wb(1'b1, 5'd7);
    #1;
    checks++;
    if (sb.stall !== !BYP) begin errors++; $display("FAIL bypass_stall: got %b want %b", sb.stall, !BYP); end
    tick();
    checks++;
    if (sb.pend[7] !== 1'b0) begin errors++; $display("FAIL bypass_clear: got %b want 0", sb.pend[7]); end
    idle();
    tick();
  endtask

  task automatic test_x0();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0);
    tick();
    checks++;
    if (sb.pend !== 32'h0) begin errors++; $display("FAIL x0_pend: got %h want 0", sb.pend); end
    drive_iss(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0);
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", sb.stall); end
    tick();
    checks++;
    if (sb.busy_cnt !== 6'd0) begin errors++; $display("FAIL x0_busy: got %0d want 0", sb.busy_cnt); end
    idle();
    tick();
  endtask

  task automatic test_waw();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
    tick();
    #1;
    checks++;
    if (sb.stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", sb.stall); end
    tick();
    checks++;
    if (sb.pend !== 32'h8) begin errors++; $display("FAIL waw_hold: got %h want 00000008", sb.pend); end
    idle();
    drive_wb(1'b1, 5'd3);
    tick();
    checks++;
    if (sb.pend[3] !== 1'b0) begin errors++; $display("FAIL waw_wb: got %b want 0", sb.pend[3]); end
    drive_wb(1'b0, 5'd0);
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL waw_reissue_stall: got %b want 0", sb.stall); end
    tick();
    checks++;
    if (sb.pend[3] !== 1'b1) begin errors++; $display("FAIL waw_reissue_pend: got %b want 1", sb.pend[3]); end
    idle();
    drive_wb(1'b1, 5'd3);
    tick();
    idle();
    tick();
  endtask

  task automatic test_wb_err();
    drive_wb(1'b1, 5'd9);
    tick();
    drive_wb(1'b0, 5'd0);
    checks++;
    if (sb.wb_err !== 1'b1) begin errors++; $display("FAIL wberr_pulse: got %b want 1", sb.wb_err); end
    tick();
    checks++;
    if (sb.wb_err !== 1'b0) begin errors++; $display("FAIL wberr_one_cycle: got %b want 0", sb.wb_err); end
    drive_wb(1'b1, 5'd9);
    sb.flush = 1'b1;
    tick();
    checks++;
    if (sb.wb_err !== 1'b0) begin errors++; $display("FAIL wberr_flush: got %b want 0", sb.wb_err); end
    idle();
    tick();
  endtask

  task automatic fill_1_2_31();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1);
    tick();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
    tick();
    drive_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd31);
    tick();
  endtask

  task automatic test_flush();
    fill_1_2_31();
    checks++;
    if (sb.busy_cnt !== 6'd3) begin errors++; $display("FAIL flush_fill_busy: got %0d want 3", sb.busy_cnt); end
    drive_iss(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4);
    sb.flush = 1'b1;
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", sb.stall); end
    tick();
    sb.flush = 1'b0;
    checks++;
    if (sb.pend !== 32'h0) begin errors++; $display("FAIL flush_pend: got %h want 0", sb.pend); end
    checks++;
    if (sb.busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_busy: got %0d want 0", sb.busy_cnt); end
    drive_iss(1'b1, 5'd1, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0);
    #1;
    checks++;
    if (sb.stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall: got %b want 0", sb.stall); end
    idle();
    tick();
    fill_1_2_31();
    idle();
    reset = 1'b1;
    tick();
    checks++;
    if (sb.pend !== 32'h0) begin errors++; $display("FAIL midreset_pend: got %h want 0", sb.pend); end
    drive_wb(1'b1, 5'd1);
    tick();
    checks++;
    if (sb.wb_err !== 1'b0) begin errors++; $display("FAIL midreset_wberr: got %b want 0", sb.wb_err); end
    reset = 1'b0;
    drive_wb(1'b1, 5'd2);
    tick();
    checks++;
    if (sb.wb_err !== 1'b1) begin errors++; $display("FAIL postreset_wberr: got %b want 1", sb.wb_err); end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive_iss(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)));
      drive_wb(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
      sb.flush = ($urandom_range(0, 99) < 4);
      reset    = ($urandom_range(0, 99) < 2);
      #1;
      checks++;
      if (sb.stall !== exp_stall())
        begin errors++; $display("FAIL rand_stall: cycle %0d got %b want %b", c, sb.stall, exp_stall()); end
      tick();
      checks++;
      if (sb.pend !== exp_pend())
        begin errors++; $display("FAIL rand_pend: cycle %0d got %h want %h", c, sb.pend, exp_pend()); end
      checks++;
      if (sb.busy_cnt !== exp_busy())
        begin errors++; $display("FAIL rand_busy: cycle %0d got %0d want %0d", c, sb.busy_cnt, exp_busy()); end
      checks++;
      if (sb.wb_err !== m_err)
        begin errors++; $display("FAIL rand_wberr: cycle %0d got %b want %b", c, sb.wb_err, m_err); end
    end
    reset = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_err = 1'b0;
    test_reset();
    test_raw();
    test_bypass();
    test_x0();
    test_waw();
    test_wb_err();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
